// File: rtl/vram_bus_arbiter_pkg.sv
// Shared definitions for the PC-8001 video/CPU SRAM arbiter: state encoding,
// SRAM address width and the text VRAM base address.
package pc8001_bus_pkg;

    localparam int SRAM_AW = 17;
    localparam logic [SRAM_AW-1:0] VRAM_BASE = 17'h0F300;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_GRANT = 2'd2,
        ST_REL   = 2'd3
    } arb_state_e;

endpackage

// File: rtl/vram_bus_arbiter_busak_sync.sv
// Single-flop register for the Z80 BUSAK_n input; resets to the released level (1)
// so the arbiter never sees a phantom acknowledge out of reset.
module busak_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic q_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            q_q <= 1'b1;
        end else begin
            q_q <= d_i;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/vram_bus_arbiter.sv
// Video DMA bus-grant responder: halts the Z80 via BUSRQ_n, grants SRAM to the video
// fetcher once BUSAK_n is seen, and muxes SRAM address/control. Optional REQ timeout
// with sticky error flag is enabled by defining ARB_TIMEOUT_EN.
module vram_bus_arbiter
    import pc8001_bus_pkg::*;
#(
    parameter int AW = SRAM_AW
`ifdef ARB_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = 256
`endif
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          vid_busreq,
    output logic          vid_busack,
    input  logic [AW-1:0] vid_adr,
    output logic [7:0]    vid_data,
    input  logic [AW-1:0] cpu_adr,
    input  logic          cpu_mreq,
    input  logic          cpu_rd,
    input  logic          cpu_wr,
    input  logic [7:0]    cpu_dout,
    output logic [7:0]    cpu_din,
    output logic          z80_busrq_n,
    input  logic          z80_busak_n,
    output logic [AW-1:0] sram_adr,
    output logic [7:0]    sram_dq_o,
    output logic          sram_dq_oe,
    input  logic [7:0]    sram_dq_i,
    output logic          sram_we_n,
    output logic          sram_oe_n,
    output logic          arb_err
);

    arb_state_e state_q, state_d;
    logic       busrq_n_q, busrq_n_d;
    logic       grant_q, grant_d;
    logic       busak_q;
    logic       start_ok;
    logic       timeout;

    busak_sync u_busak_sync (
        .clk_i (CLK),
        .rst_i (RST),
        .d_i   (z80_busak_n),
        .q_o   (busak_q)
    );

`ifdef ARB_TIMEOUT_EN
    localparam int CW = (TIMEOUT_CYC > 256) ? $clog2(TIMEOUT_CYC) : 8;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q;
    logic          blk_q;

    // Timeout only fires while the request is still live and unacknowledged.
    assign cnt_d    = (state_q == ST_REQ) ? cnt_q + 1'b1 : '0;
    assign timeout  = (state_q == ST_REQ) && vid_busreq && busak_q &&
                      (cnt_q == CW'(TIMEOUT_CYC - 1));
    assign start_ok = vid_busreq && !blk_q;
    assign arb_err  = err_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt_q <= '0;
            err_q <= 1'b0;
            blk_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            if (timeout) begin
                err_q <= 1'b1;
            end
            // A timed-out request must drop before it may be retried.
            if (timeout) begin
                blk_q <= 1'b1;
            end else if (!vid_busreq) begin
                blk_q <= 1'b0;
            end
        end
    end
`else
    assign timeout  = 1'b0;
    assign start_ok = vid_busreq;
    assign arb_err  = 1'b0;
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= ST_IDLE;
            busrq_n_q <= 1'b1;
            grant_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            busrq_n_q <= busrq_n_d;
            grant_q   <= grant_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        busrq_n_d = busrq_n_q;
        grant_d   = grant_q;
        case (state_q)
            ST_IDLE: begin
                busrq_n_d = 1'b1;
                grant_d   = 1'b0;
                if (start_ok) begin
                    state_d   = ST_REQ;
                    busrq_n_d = 1'b0;
                end
            end
            ST_REQ: begin
                if (!vid_busreq) begin
                    state_d   = ST_REL;
                    busrq_n_d = 1'b1;
                end else if (!busak_q) begin
                    state_d = ST_GRANT;
                    grant_d = 1'b1;
                end else if (timeout) begin
                    state_d   = ST_REL;
                    busrq_n_d = 1'b1;
                end
            end
            ST_GRANT: begin
                // Losing BUSAK_n here means the Z80 was reset under us.
                if (!vid_busreq || busak_q) begin
                    state_d   = ST_REL;
                    grant_d   = 1'b0;
                    busrq_n_d = 1'b1;
                end
            end
            ST_REL: begin
                busrq_n_d = 1'b1;
                grant_d   = 1'b0;
                if (busak_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                busrq_n_d = 1'b1;
                grant_d   = 1'b0;
            end
        endcase
    end

    assign vid_busack  = grant_q;
    assign z80_busrq_n = busrq_n_q;

    // SRAM mux: a CPU write during GRANT is a protocol violation and is dropped.
    always_comb begin
        if (state_q == ST_GRANT) begin
            sram_adr   = vid_adr;
            sram_oe_n  = 1'b0;
            sram_we_n  = 1'b1;
            sram_dq_oe = 1'b0;
        end else begin
            sram_adr   = cpu_adr;
            sram_oe_n  = ~(cpu_mreq & cpu_rd);
            sram_we_n  = ~(cpu_mreq & cpu_wr);
            sram_dq_oe = cpu_mreq & cpu_wr;
        end
    end

    assign sram_dq_o = cpu_dout;
    assign vid_data  = sram_dq_i;
    assign cpu_din   = sram_dq_i;

endmodule

// File: tb/tb_vram_bus_arbiter.sv
// Directed bench for vram_bus_arbiter: handshake latency, SRAM muxing, release,
// reset mid-burst and the REQ wait / timeout behaviour (ARB_TIMEOUT_EN).
module tb_vram_bus_arbiter;
    import pc8001_bus_pkg::*;

    localparam int AW = 17;

    logic          CLK = 1'b0;
    logic          RST;
    logic          vid_busreq;
    logic          vid_busack;
    logic [AW-1:0] vid_adr;
    logic [7:0]    vid_data;
    logic [AW-1:0] cpu_adr;
    logic          cpu_mreq;
    logic          cpu_rd;
    logic          cpu_wr;
    logic [7:0]    cpu_dout;
    logic [7:0]    cpu_din;
    logic          z80_busrq_n;
    logic          z80_busak_n;
    logic [AW-1:0] sram_adr;
    logic [7:0]    sram_dq_o;
    logic          sram_dq_oe;
    logic [7:0]    sram_dq_i;
    logic          sram_we_n;
    logic          sram_oe_n;
    logic          arb_err;

    int tests = 0;
    int fails = 0;

    vram_bus_arbiter #(.AW(AW)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .vid_busreq  (vid_busreq),
        .vid_busack  (vid_busack),
        .vid_adr     (vid_adr),
        .vid_data    (vid_data),
        .cpu_adr     (cpu_adr),
        .cpu_mreq    (cpu_mreq),
        .cpu_rd      (cpu_rd),
        .cpu_wr      (cpu_wr),
        .cpu_dout    (cpu_dout),
        .cpu_din     (cpu_din),
        .z80_busrq_n (z80_busrq_n),
        .z80_busak_n (z80_busak_n),
        .sram_adr    (sram_adr),
        .sram_dq_o   (sram_dq_o),
        .sram_dq_oe  (sram_dq_oe),
        .sram_dq_i   (sram_dq_i),
        .sram_we_n   (sram_we_n),
        .sram_oe_n   (sram_oe_n),
        .arb_err     (arb_err)
    );

    always #5 CLK = ~CLK;

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic cpu_idle();
        cpu_mreq = 1'b0;
        cpu_rd   = 1'b0;
        cpu_wr   = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1; vid_busreq = 1'b0; vid_adr = '0; cpu_adr = '0;
        cpu_dout = 8'h00; sram_dq_i = 8'h00; z80_busak_n = 1'b1;
        cpu_idle();
        tick(3);
        RST = 1'b0;
        tick(1);
        tests++;
        if ({z80_busrq_n, vid_busack, sram_we_n, sram_oe_n, sram_dq_oe, arb_err} !== 6'b101100) begin
            fails++;
            $display("FAIL reset_state got busrq_n/busack/we_n/oe_n/dq_oe/err=%b want 101100",
                     {z80_busrq_n, vid_busack, sram_we_n, sram_oe_n, sram_dq_oe, arb_err});
        end
    endtask

    task automatic test_grant_latency();
        vid_busreq = 1'b1;
        tick(1);
        tests++;
        if (z80_busrq_n !== 1'b0 || vid_busack !== 1'b0) begin
            fails++;
            $display("FAIL req_latency got busrq_n=%b busack=%b want 0 0", z80_busrq_n, vid_busack);
        end
        tick(4);
        z80_busak_n = 1'b0;
        tick(1);
        tests++;
        if (vid_busack !== 1'b0) begin
            fails++;
            $display("FAIL busack_early got %b want 0", vid_busack);
        end
        tick(1);
        tests++;
        if (vid_busack !== 1'b1 || z80_busrq_n !== 1'b0) begin
            fails++;
            $display("FAIL busack_latency got busack=%b busrq_n=%b want 1 0", vid_busack, z80_busrq_n);
        end
    endtask

    task automatic test_vid_read();
        vid_adr   = VRAM_BASE;
        sram_dq_i = 8'h41;
        cpu_adr   = 17'h00123;
        #1;
        tests++;
        if (sram_adr !== 17'h0F300 || sram_oe_n !== 1'b0 || sram_we_n !== 1'b1 ||
            sram_dq_oe !== 1'b0 || vid_data !== 8'h41) begin
            fails++;
            $display("FAIL vid_read got adr=%h oe_n=%b we_n=%b dq_oe=%b data=%h want 0f300 0 1 0 41",
                     sram_adr, sram_oe_n, sram_we_n, sram_dq_oe, vid_data);
        end
    endtask

    task automatic test_cpu_write_blocked();
        cpu_adr = 17'h08000; cpu_dout = 8'hAA;
        cpu_mreq = 1'b1; cpu_wr = 1'b1;
        #1;
        tests++;
        if (sram_we_n !== 1'b1 || sram_adr !== 17'h0F300 || sram_dq_oe !== 1'b0) begin
            fails++;
            $display("FAIL wr_in_grant got we_n=%b adr=%h dq_oe=%b want 1 0f300 0",
                     sram_we_n, sram_adr, sram_dq_oe);
        end
        tick(1);
        tests++;
        if (sram_we_n !== 1'b1 || vid_busack !== 1'b1) begin
            fails++;
            $display("FAIL wr_in_grant_hold got we_n=%b busack=%b want 1 1", sram_we_n, vid_busack);
        end
        cpu_idle();
    endtask

    task automatic test_release();
        vid_busreq = 1'b0;
        tick(1);
        tests++;
        if (vid_busack !== 1'b0 || z80_busrq_n !== 1'b1) begin
            fails++;
            $display("FAIL release got busack=%b busrq_n=%b want 0 1", vid_busack, z80_busrq_n);
        end
        z80_busak_n = 1'b1;
        tick(2);
        // Now in IDLE: a new request must assert BUSRQ_n on the very next edge.
        vid_busreq = 1'b1;
        tick(1);
        tests++;
        if (z80_busrq_n !== 1'b0) begin
            fails++;
            $display("FAIL idle_after_rel got busrq_n=%b want 0", z80_busrq_n);
        end
        vid_busreq = 1'b0;
        tick(1);
        tests++;
        if (z80_busrq_n !== 1'b1 || vid_busack !== 1'b0) begin
            fails++;
            $display("FAIL req_abort got busrq_n=%b busack=%b want 1 0", z80_busrq_n, vid_busack);
        end
        tick(1);
    endtask

    task automatic test_cpu_mux();
        cpu_adr = 17'h1ABCD; cpu_dout = 8'h5A; cpu_mreq = 1'b1; cpu_wr = 1'b1;
        #1;
        tests++;
        if (sram_adr !== 17'h1ABCD || sram_we_n !== 1'b0 || sram_oe_n !== 1'b1 ||
            sram_dq_oe !== 1'b1 || sram_dq_o !== 8'h5A) begin
            fails++;
            $display("FAIL cpu_write got adr=%h we_n=%b oe_n=%b dq_oe=%b dq_o=%h want 1abcd 0 1 1 5a",
                     sram_adr, sram_we_n, sram_oe_n, sram_dq_oe, sram_dq_o);
        end
        cpu_wr = 1'b0; cpu_rd = 1'b1; cpu_adr = 17'h00042; sram_dq_i = 8'hC3;
        #1;
        tests++;
        if (sram_adr !== 17'h00042 || sram_oe_n !== 1'b0 || sram_we_n !== 1'b1 ||
            sram_dq_oe !== 1'b0 || cpu_din !== 8'hC3) begin
            fails++;
            $display("FAIL cpu_read got adr=%h oe_n=%b we_n=%b dq_oe=%b din=%h want 00042 0 1 0 c3",
                     sram_adr, sram_oe_n, sram_we_n, sram_dq_oe, cpu_din);
        end
        cpu_mreq = 1'b0; cpu_wr = 1'b1; cpu_rd = 1'b1;
        #1;
        tests++;
        if (sram_we_n !== 1'b1 || sram_oe_n !== 1'b1 || sram_dq_oe !== 1'b0) begin
            fails++;
            $display("FAIL cpu_no_mreq got we_n=%b oe_n=%b dq_oe=%b want 1 1 0",
                     sram_we_n, sram_oe_n, sram_dq_oe);
        end
        cpu_idle();
        tick(1);
    endtask

    task automatic test_rel_rerequest();
        vid_busreq = 1'b1; z80_busak_n = 1'b0;
        tick(3);
        tests++;
        if (vid_busack !== 1'b1) begin
            fails++;
            $display("FAIL rereq_setup got busack=%b want 1", vid_busack);
        end
        vid_busreq = 1'b0;
        tick(1);
        vid_busreq = 1'b1;
        tick(1);
        z80_busak_n = 1'b1;
        tick(2);
        tests++;
        if (z80_busrq_n !== 1'b1 || vid_busack !== 1'b0) begin
            fails++;
            $display("FAIL rereq_idle got busrq_n=%b busack=%b want 1 0", z80_busrq_n, vid_busack);
        end
        tick(1);
        tests++;
        if (z80_busrq_n !== 1'b0) begin
            fails++;
            $display("FAIL rereq_serviced got busrq_n=%b want 0", z80_busrq_n);
        end
        z80_busak_n = 1'b0;
        tick(2);
        tests++;
        if (vid_busack !== 1'b1) begin
            fails++;
            $display("FAIL rereq_grant got busack=%b want 1", vid_busack);
        end
    endtask

    task automatic test_busak_lost();
        // Z80 drops BUSAK_n while granted: one sync cycle, then grant falls.
        z80_busak_n = 1'b1;
        tick(1);
        tests++;
        if (vid_busack !== 1'b1) begin
            fails++;
            $display("FAIL busak_lost_sync got busack=%b want 1", vid_busack);
        end
        tick(1);
        tests++;
        if (vid_busack !== 1'b0 || z80_busrq_n !== 1'b1) begin
            fails++;
            $display("FAIL busak_lost got busack=%b busrq_n=%b want 0 1", vid_busack, z80_busrq_n);
        end
        vid_busreq = 1'b0;
        tick(3);
    endtask

    task automatic test_reset_midburst();
        vid_busreq = 1'b1; z80_busak_n = 1'b0;
        tick(3);
        tests++;
        if (vid_busack !== 1'b1) begin
            fails++;
            $display("FAIL rst_setup got busack=%b want 1", vid_busack);
        end
        #2;
        RST = 1'b1;
        #1;
        tests++;
        if (vid_busack !== 1'b0 || z80_busrq_n !== 1'b1 || sram_we_n !== 1'b1 || sram_oe_n !== 1'b1) begin
            fails++;
            $display("FAIL rst_async got busack=%b busrq_n=%b we_n=%b oe_n=%b want 0 1 1 1",
                     vid_busack, z80_busrq_n, sram_we_n, sram_oe_n);
        end
        vid_busreq = 1'b0; z80_busak_n = 1'b1;
        tick(1);
        RST = 1'b0;
        tick(2);
    endtask

`ifdef ARB_TIMEOUT_EN
    task automatic test_timeout();
        vid_busreq = 1'b1;
        tick(256);
        tests++;
        if (z80_busrq_n !== 1'b0 || vid_busack !== 1'b0 || arb_err !== 1'b0) begin
            fails++;
            $display("FAIL timeout_early got busrq_n=%b busack=%b err=%b want 0 0 0",
                     z80_busrq_n, vid_busack, arb_err);
        end
        tick(1);
        tests++;
        if (z80_busrq_n !== 1'b1 || vid_busack !== 1'b0 || arb_err !== 1'b1) begin
            fails++;
            $display("FAIL timeout got busrq_n=%b busack=%b err=%b want 1 0 1",
                     z80_busrq_n, vid_busack, arb_err);
        end
        tick(4);
        tests++;
        if (z80_busrq_n !== 1'b1 || arb_err !== 1'b1) begin
            fails++;
            $display("FAIL timeout_no_retry got busrq_n=%b err=%b want 1 1", z80_busrq_n, arb_err);
        end
        vid_busreq = 1'b0;
        tick(1);
        vid_busreq = 1'b1;
        tick(1);
        tests++;
        if (z80_busrq_n !== 1'b0 || arb_err !== 1'b1) begin
            fails++;
            $display("FAIL timeout_retry got busrq_n=%b err=%b want 0 1", z80_busrq_n, arb_err);
        end
        vid_busreq = 1'b0;
        tick(2);
    endtask
`else
    task automatic test_req_wait();
        vid_busreq = 1'b1;
        tick(300);
        tests++;
        if (z80_busrq_n !== 1'b0 || vid_busack !== 1'b0 || arb_err !== 1'b0) begin
            fails++;
            $display("FAIL req_wait got busrq_n=%b busack=%b err=%b want 0 0 0",
                     z80_busrq_n, vid_busack, arb_err);
        end
        z80_busak_n = 1'b0;
        tick(2);
        tests++;
        if (vid_busack !== 1'b1) begin
            fails++;
            $display("FAIL req_wait_grant got busack=%b want 1", vid_busack);
        end
        vid_busreq = 1'b0; z80_busak_n = 1'b1;
        tick(3);
    endtask
`endif

    initial begin
        test_reset();
        test_grant_latency();
        test_vid_read();
        test_cpu_write_blocked();
        test_release();
        test_cpu_mux();
        test_rel_rerequest();
        test_busak_lost();
        test_reset_midburst();
`ifdef ARB_TIMEOUT_EN
        test_timeout();
`else
        test_req_wait();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
